// File: rtl/mult_div_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mult_div_unit: iterative 32-cycle multiply/divide unit with HI/LO registers.|
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module mult_div_unit #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic          hi_we,
  input  logic          lo_we,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] HI,
  output logic [DW-1:0] LO
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    r_state;
  logic [4:0]    r_cnt;
  logic          r_is_div;
  logic          r_neg_q;
  logic          r_neg_r;
  logic          r_dz;
  logic          r_done;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_m;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] r_q;
  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo;

  logic          w_a_neg;
  logic          w_b_neg;
  logic [DW-1:0] w_a_mag;
  logic [DW-1:0] w_b_mag;
  logic [DW:0]   w_madd;
  logic [DW:0]   w_sh;
  logic          w_ge;
  logic [DW-1:0] w_sub;
  logic [DW-1:0] w_acc_nx;
  logic [DW-1:0] w_q_nx;
  logic [2*DW-1:0] w_prod;
  logic [2*DW-1:0] w_prod_fix;
  logic [DW-1:0] w_hi_res;
  logic [DW-1:0] w_lo_res;

  // Signed operations run on magnitudes; signs are reapplied at completion.
  assign w_a_neg = op[0] & A[DW-1];
  assign w_b_neg = op[0] & B[DW-1];
  assign w_a_mag = w_a_neg ? -A : A;
  assign w_b_mag = w_b_neg ? -B : B;

  // r_q holds the multiplier (shifted out LSB-first) or the dividend (MSB-first).
  assign w_madd = {1'b0, r_acc} + {1'b0, (r_q[0] ? r_m : {DW{1'b0}})};
  assign w_sh   = {r_acc, r_q[DW-1]};
  assign w_ge   = (w_sh >= {1'b0, r_m});
  assign w_sub  = w_sh[DW-1:0] - r_m;

  always_comb begin
    if (r_is_div) begin
      w_acc_nx = w_ge ? w_sub : w_sh[DW-1:0];
      w_q_nx   = {r_q[DW-2:0], w_ge};
    end else begin
      w_acc_nx = w_madd[DW:1];
      w_q_nx   = {w_madd[0], r_q[DW-1:1]};
    end
  end

  assign w_prod     = {w_acc_nx, w_q_nx};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  always_comb begin
    w_hi_res = w_prod_fix[2*DW-1:DW];
    w_lo_res = w_prod_fix[DW-1:0];
    if (r_is_div) begin
      if (r_dz) begin
        w_hi_res = r_a;
        w_lo_res = {DW{1'b1}};
      end else begin
        w_hi_res = r_neg_r ? -w_acc_nx : w_acc_nx;
        w_lo_res = r_neg_q ? -w_q_nx : w_q_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_a      <= {DW{1'b0}};
      r_m      <= {DW{1'b0}};
      r_acc    <= {DW{1'b0}};
      r_q      <= {DW{1'b0}};
      r_hi     <= {DW{1'b0}};
      r_lo     <= {DW{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_state  <= S_RUN;
            r_cnt    <= 5'd0;
            r_is_div <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= (B == {DW{1'b0}});
            r_a      <= A;
            r_m      <= w_b_mag;
            r_acc    <= {DW{1'b0}};
            r_q      <= w_a_mag;
          end
        end
        default: begin
          r_acc <= w_acc_nx;
          r_q   <= w_q_nx;
          r_cnt <= r_cnt + 5'd1;
          // HI/LO only ever see the finished result, never partial state.
          if (r_cnt == 5'd31) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_hi    <= w_hi_res;
            r_lo    <= w_lo_res;
          end
        end
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mult_div_unit: randomized + directed self-checking bench for the unit.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_total = 0;
  int n_bad   = 0;

  mult_div_unit #(.DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Returns {HI, LO} from plain wide arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: p = {32'd0, a} * {32'd0, b};
      2'b01: p = 64'(sa * sb);
      default: begin
        if (b == 32'd0) begin
          p = {a, 32'hFFFFFFFF};
        end else if (o == 2'b10) begin
          p = {a % b, a / b};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  // Cycle-level model: what the outputs must be after each edge.
  logic        m_busy;
  logic        m_done;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          m_cnt;
  logic [63:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_cnt  <= 0;
      m_res  <= 64'd0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
        if (start) begin
          m_busy <= 1'b1;
          m_cnt  <= 1;
          m_res  <= ref_result(op, A, B);
        end
      end else if (m_cnt == 32) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_hi   <= m_res[63:32];
        m_lo   <= m_res[31:0];
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("model_busy", {63'd0, busy}, {63'd0, m_busy});
      chk("model_done", {63'd0, done}, {63'd0, m_done});
      chk("model_hilo", {HI, LO}, {m_hi, m_lo});
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk({nm, "_busy"}, {63'd0, busy}, 64'd1);
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'd33);
    chk({nm, "_hi"}, {32'd0, HI}, {32'd0, ehi});
    chk({nm, "_lo"}, {32'd0, LO}, {32'd0, elo});
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, {63'd0, done}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; A = 32'd0; B = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;

    chk("pin_multu", ref_result(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
    chk("pin_mult",  ref_result(2'b01, 32'hFFFFFFFD, 32'd5), 64'hFFFFFFFF_FFFFFFF1);
    chk("pin_div",   ref_result(2'b11, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    chk("pin_divov", ref_result(2'b11, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

    repeat (2) @(negedge clk);
    chk("reset_state", {busy, done, HI, LO}, 66'd0);
    rst_n = 1'b1;

    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    run_op(2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg");
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    run_op(2'b10, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, "divu_zero");
    run_op(2'b11, 32'hFFFFFF9C, 32'd0, 32'hFFFFFF9C, 32'hFFFFFFFF, "div_zero");
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf");

    // Second start mid-operation must be ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b10; A = 32'd10; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 1; i < 40; i++) begin
      if (i == 4) begin start = 1'b1; op = 2'b00; A = 32'd2; B = 32'd2; end
      if (i == 5) start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("ignore_start_dones", 64'(ndone), 64'd1);
    chk("ignore_start_hilo", {HI, LO}, {32'd1, 32'd3});

    // Mid-operation reset, then MTHI from IDLE.
    @(negedge clk);
    start = 1'b1; op = 2'b00; A = 32'd7; B = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {busy, done, HI, LO}, 66'd0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("reset_no_done", 64'(ndone), 64'd0);
    hi_we = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_idle", {32'd0, HI}, 64'h12345678);
    run_op(2'b00, 32'd7, 32'd6, 32'd0, 32'd42, "multu_after_reset");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = (($urandom % 4) == 0);
      op    = 2'($urandom);
      A     = pick();
      B     = pick();
      hi_we = (($urandom % 8) == 0);
      lo_we = (($urandom % 8) == 0);
      wdata = $urandom;
      if (i == 1500) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rand_async_reset", {busy, done, HI, LO}, 66'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: DW, 32, operand width; only 32 is supported.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: start  in  1  operation request, sampled on rising clk edge.
REQ-005 Port: op  in  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
REQ-006 Port: A  in  32  operand 1 (multiplicand/dividend), fed from register file Q1.
REQ-007 Port: B  in  32  operand 2 (multiplier/divisor), fed from register file Q2.
REQ-008 Port: hi_we  in  1  MTHI write enable.
REQ-009 Port: lo_we  in  1  MTLO write enable.
REQ-010 Port: wdata  in  32  data for MTHI/MTLO.
REQ-011 Port: busy  out  1  operation in progress.
REQ-012 Port: done  out  1  single-cycle completion pulse.
REQ-013 Port: HI  out  32  product high word / remainder.
REQ-014 Port: LO  out  32  product low word / quotient.

Function
REQ-015 States SHALL be IDLE and RUN; IDLE -> RUN on start=1; RUN -> IDLE after 32 iteration cycles.
REQ-016 start SHALL be accepted only in IDLE; A, B, op SHALL be latched at the accepting edge (T0) and not re-sampled.
REQ-017 busy SHALL be 1 from edge T0 until edge T32; done SHALL be 1 for exactly the cycle after T32; HI/LO SHALL update at T32.
REQ-018 start while busy=1 SHALL be ignored, with no effect on the running operation.
REQ-019 Multiply SHALL be a 32-step shift-add producing the full 64-bit product {HI,LO}; MULT treats operands as two's complement.
REQ-020 Divide SHALL be a 32-step restoring division; LO=quotient, HI=remainder.
REQ-021 Signed ops SHALL operate on magnitudes; quotient negated if operand signs differ; remainder takes the dividend's sign; product negated if signs differ.
REQ-022 Divide by zero (B=0) SHALL still take 32 cycles and yield LO=0xFFFFFFFF, HI=A (unsigned and signed).
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000.
REQ-024 HI/LO SHALL hold their values except on completion, hi_we/lo_we, or reset.
REQ-025 hi_we/lo_we in IDLE SHALL write wdata to HI/LO at that edge; hi_we/lo_we while busy=1 SHALL be ignored.
REQ-026 hi_we/lo_we together with an accepted start SHALL perform the write and also start the operation; the result overwrites at T32.
REQ-027 In the done cycle the unit SHALL be IDLE: a new start or MTHI/MTLO in that cycle SHALL be accepted.
REQ-028 Intermediate partial results SHALL NOT be visible on HI/LO.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, HI=0, LO=0, and clear the iteration counter, regardless of clk.
REQ-030 Reset asserted mid-operation SHALL abort it with no completion pulse; after rst_n release the first start SHALL behave per REQ-017.

Verification
REQ-031 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> busy for 32 cycles, done pulse, HI=0xFFFFFFFE LO=0x00000001.
REQ-032 MULT A=0xFFFFFFFD(-3) B=5 -> HI=0xFFFFFFFF LO=0xFFFFFFF1; DIV A=0xFFFFFFF9(-7) B=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF.
REQ-033 DIVU A=100 B=0 -> LO=0xFFFFFFFF HI=0x00000064 after 32 cycles.
REQ-034 start with DIVU 10/3, then a second start (MULTU 2*2) at cycle 5 -> second start ignored; result LO=3 HI=1; exactly one done pulse.
REQ-035 MULTU 7*6 started, rst_n low at cycle 10 -> busy=0, HI=LO=0 immediately, no done; hi_we in IDLE with wdata=0x12345678 -> HI=0x12345678 next edge.
